// File: rtl/vga_pkg.sv
// Shared window geometry, FSM state encoding and the display-window test.
package vga_pkg;

    localparam int unsigned WIN_W = 512;
    localparam int unsigned WIN_H = 128;
    localparam logic [10:0] OFF_X = 11'h7ff;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DISP  = 2'd1,
        ST_WRITE = 2'd2
    } vga_state_e;

    // The timing generator marks off-window positions with OFF_X; the range
    // test already rejects it, the explicit compare keeps the intent visible.
    function automatic logic in_window(input logic [10:0] x, input logic [10:0] y);
        if ((x == OFF_X) || (y == OFF_X)) begin
            return 1'b0;
        end
        return (x < 11'(WIN_W)) && (y < 11'(WIN_H));
    endfunction

endpackage

// File: rtl/vga_wr_fifo.sv
// Write-request FIFO: first-word fall-through, head visible on pop_data_o.
module vga_wr_fifo #(
    parameter int W     = 28,
    parameter int DEPTH = 4
) (
    input  logic         clk25M,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_ptr_q;
    logic [PW:0]  rd_ptr_q;
    logic         push_ok;
    logic         pop_ok;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q[PW-1:0]];

    // Pointer update; reset flushes every queued request.
    always_ff @(posedge clk25M or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Entry storage; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk25M) begin
        if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: display reads win over queued writer requests.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | no pixel, no pending write; memory port idle, address held
//  ST_DISP  | in-window pixel; port reads {y[6:0], x[8:0]}
//  ST_WRITE | outside window with FIFO non-empty; one entry written
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk25M,
    input  logic          reset_n,
    input  logic [10:0]   disp_x,
    input  logic [10:0]   disp_y,
    input  logic          frame_start,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rgb_out,
    output logic          wr_pending,
    output logic [7:0]    frame_cnt
);

    vga_state_e   state_q, state_d;
    logic         act;
    logic         rdy_en_q;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic          pix_d2_q;
    logic [DW-1:0] rgb_q;
    logic [7:0]    frame_q;

    assign act = in_window(disp_x, disp_y);

    // Ready is held off until the first edge after reset release.
    assign wr_ready  = rdy_en_q && !fifo_full;
    assign fifo_push = wr_valid && wr_ready;

    vga_wr_fifo #(
        .W     (AW + DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk25M      (clk25M),
        .reset_n     (reset_n),
        .push_i      (fifo_push),
        .push_data_i ({wr_addr, wr_data}),
        .pop_i       (fifo_pop),
        .pop_data_o  ({head_addr, head_data}),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Next-state and memory-port decision; act is checked first so a rising
    // window suppresses the pop in the very same cycle.
    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if (act) begin
            state_d    = ST_DISP;
            mem_addr_d = AW'({disp_y[6:0], disp_x[8:0]});
        end else if (!fifo_empty) begin
            state_d     = ST_WRITE;
            fifo_pop    = 1'b1;
            mem_addr_d  = head_addr;
            mem_wdata_d = head_data;
            mem_we_d    = 1'b1;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // State and registered memory-port outputs.
    always_ff @(posedge clk25M or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rdy_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_en_q    <= 1'b1;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    // Pixel pipeline: a DISP cycle's read data arrives one cycle later and is
    // registered onto rgb_out; non-window pixels are forced to black.
    always_ff @(posedge clk25M or negedge reset_n) begin
        if (!reset_n) begin
            pix_d2_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            pix_d2_q <= (state_q == ST_DISP);
            rgb_q    <= pix_d2_q ? mem_rdata : '0;
        end
    end

    // Frame counter, free-running modulo 256.
    always_ff @(posedge clk25M or negedge reset_n) begin
        if (!reset_n) begin
            frame_q <= '0;
        end else if (frame_start) begin
            frame_q <= frame_q + 8'd1;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign rgb_out    = rgb_q;
    assign wr_pending = !fifo_empty;
    assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a simple address-echo RAM model.
module tb_vga_fb_arbiter;

    localparam int AW = 16;
    localparam int DW = 12;
    localparam logic [10:0] OFF = 11'h7ff;

    logic          clk25M = 1'b0;
    logic          reset_n = 1'b0;
    logic [10:0]   disp_x = OFF;
    logic [10:0]   disp_y = OFF;
    logic          frame_start = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] rgb_out;
    logic          wr_pending;
    logic [7:0]    frame_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [AW+DW-1:0] wlog[$];

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        act;
        logic [15:0] addr;
    } pix_t;
    pix_t pv[6];

    vga_fb_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(4)) dut (
        .clk25M      (clk25M),
        .reset_n     (reset_n),
        .disp_x      (disp_x),
        .disp_y      (disp_y),
        .frame_start (frame_start),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .rgb_out     (rgb_out),
        .wr_pending  (wr_pending),
        .frame_cnt   (frame_cnt)
    );

    always #20 clk25M = ~clk25M;

    // RAM model: read data is the low bits of the registered address.
    always @(posedge clk25M) mem_rdata <= mem_addr[DW-1:0];

    // Record every write cycle as {addr, data}.
    always @(negedge clk25M) begin
        if (mem_we === 1'b1) wlog.push_back({mem_addr, mem_wdata});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk25M);
            #1;
        end
    endtask

    task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick(1);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(1);
    endtask

    function automatic logic [AW+DW-1:0] log_at(input int i);
        if (i < wlog.size()) return wlog[i];
        return '1;
    endfunction

    initial begin
        logic [15:0] last_addr;

        pv[0] = '{x: 11'd5,   y: 11'd3,   act: 1'b1, addr: 16'h0605};
        pv[1] = '{x: 11'd511, y: 11'd127, act: 1'b1, addr: 16'hffff};
        pv[2] = '{x: 11'd512, y: 11'd0,   act: 1'b0, addr: 16'h0000};
        pv[3] = '{x: 11'd0,   y: 11'd128, act: 1'b0, addr: 16'h0000};
        pv[4] = '{x: 11'd3,   y: OFF,     act: 1'b0, addr: 16'h0000};
        pv[5] = '{x: 11'd0,   y: 11'd0,   act: 1'b1, addr: 16'h0000};

        // Reset values while held in reset
        #5;
        check_eq("rst_wr_ready", wr_ready, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_rgb", rgb_out, 0);
        check_eq("rst_frame", frame_cnt, 0);
        check_eq("rst_pending", wr_pending, 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check_eq("rel_mem_we", mem_we, 0);
        check_eq("rel_wr_ready", wr_ready, 1);

        // Pixel reads, window boundaries and rgb latency
        last_addr = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            disp_x = pv[i].x;
            disp_y = pv[i].y;
            tick(1);
            if (pv[i].act) last_addr = pv[i].addr;
            check_eq("pix_addr", mem_addr, last_addr);
            check_eq("pix_we", mem_we, 0);
            disp_x = OFF;
            disp_y = OFF;
            tick(1);
            check_eq("pix_rgb_early", rgb_out, 0);
            tick(1);
            check_eq("pix_rgb", rgb_out, pv[i].act ? {20'd0, last_addr[11:0]} : 32'd0);
        end

        // Fill FIFO during continuous display, then drain
        wlog.delete();
        disp_x = 11'd0;
        disp_y = 11'd0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 16'h0100 + 16'(i);
            wr_data  = 12'h0a0 + 12'(i);
            check_eq("fill_ready", wr_ready, 1);
            tick(1);
        end
        wr_addr = 16'h0104;
        wr_data = 12'h0a4;
        check_eq("full_ready", wr_ready, 0);
        check_eq("full_pending", wr_pending, 1);
        tick(2);
        check_eq("full_ready_hold", wr_ready, 0);
        check_eq("full_no_we", mem_we, 0);
        disp_x = OFF;
        disp_y = OFF;
        tick(1);
        check_eq("drain_we", mem_we, 1);
        check_eq("drain_addr0", mem_addr, 16'h0100);
        check_eq("drain_data0", mem_wdata, 12'h0a0);
        check_eq("drain_ready", wr_ready, 1);
        tick(1);
        wr_valid = 1'b0;
        tick(6);
        check_eq("drain_count", wlog.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_eq("drain_order", log_at(i), {16'h0100 + 16'(i), 12'h0a0 + 12'(i)});
        end
        check_eq("drain_empty", wr_pending, 0);

        // Single write queued during display, issued when display ends
        disp_x = 11'd10;
        disp_y = 11'd10;
        push_one(16'h1234, 12'habc);
        tick(2);
        check_eq("one_we_hold", mem_we, 0);
        check_eq("one_pending", wr_pending, 1);
        wlog.delete();
        disp_x = OFF;
        disp_y = OFF;
        tick(1);
        check_eq("one_we", mem_we, 1);
        check_eq("one_addr", mem_addr, 16'h1234);
        check_eq("one_data", mem_wdata, 12'habc);
        tick(1);
        check_eq("one_we_off", mem_we, 0);
        check_eq("one_pending_off", wr_pending, 0);
        tick(3);
        check_eq("one_count", wlog.size(), 1);

        // Display rises with two entries still queued
        disp_x = 11'd20;
        disp_y = 11'd20;
        push_one(16'h2001, 12'h111);
        push_one(16'h2002, 12'h222);
        push_one(16'h2003, 12'h333);
        wlog.delete();
        disp_x = OFF;
        disp_y = OFF;
        tick(1);
        check_eq("rise_first_we", mem_we, 1);
        check_eq("rise_first_addr", mem_addr, 16'h2001);
        disp_x = 11'd20;
        disp_y = 11'd20;
        tick(1);
        check_eq("rise_we", mem_we, 0);
        check_eq("rise_pending", wr_pending, 1);
        tick(2);
        check_eq("rise_we_hold", mem_we, 0);
        check_eq("rise_count1", wlog.size(), 1);
        disp_x = OFF;
        disp_y = OFF;
        tick(1);
        check_eq("rise_b_addr", mem_addr, 16'h2002);
        check_eq("rise_b_we", mem_we, 1);
        tick(1);
        check_eq("rise_c_addr", mem_addr, 16'h2003);
        check_eq("rise_c_data", mem_wdata, 12'h333);
        tick(2);
        check_eq("rise_count3", wlog.size(), 3);
        check_eq("rise_log1", log_at(1), {16'h2002, 12'h222});
        check_eq("rise_log2", log_at(2), {16'h2003, 12'h333});

        // Frame counter
        for (int i = 0; i < 3; i++) pulse_frame();
        check_eq("frame3", frame_cnt, 3);

        // Reset with entries queued
        disp_x = 11'd1;
        disp_y = 11'd1;
        push_one(16'h3001, 12'h001);
        push_one(16'h3002, 12'h002);
        push_one(16'h3003, 12'h003);
        check_eq("pre_rst_pending", wr_pending, 1);
        reset_n = 1'b0;
        #1;
        check_eq("arst_pending", wr_pending, 0);
        check_eq("arst_ready", wr_ready, 0);
        check_eq("arst_we", mem_we, 0);
        check_eq("arst_frame", frame_cnt, 0);
        check_eq("arst_addr", mem_addr, 0);
        tick(2);
        disp_x = OFF;
        disp_y = OFF;
        reset_n = 1'b1;
        wlog.delete();
        tick(1);
        check_eq("arel_we", mem_we, 0);
        tick(8);
        check_eq("arel_count", wlog.size(), 0);
        check_eq("arel_pending", wr_pending, 0);

        // Frame counter wrap
        for (int i = 0; i < 255; i++) pulse_frame();
        check_eq("frame255", frame_cnt, 255);
        pulse_frame();
        check_eq("frame_wrap", frame_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, frame-buffer address width (512x128 window).
REQ-002 SHALL have parameter DW, default 12, pixel width (RGB444).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, write-request FIFO entries (power of two).
REQ-004 SHALL have port clk25M  input  1  pixel clock; sole clock.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port disp_x  input  11  display column from timing generator; 11'h7ff = left of window.
REQ-007 SHALL have port disp_y  input  11  display row; 11'h7ff = above window.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse per frame (vsync edge).
REQ-009 SHALL have ports wr_valid input 1, wr_addr input AW, wr_data input DW, wr_ready output 1: writer request channel.
REQ-010 SHALL have ports mem_addr output AW, mem_we output 1, mem_wdata output DW, mem_rdata input DW: single-port synchronous RAM, read latency 1.
REQ-011 SHALL have ports rgb_out output DW (pixel to display), wr_pending output 1 (FIFO non-empty), frame_cnt output 8 (frames seen).

Function
REQ-012 SHALL define display-active (act) as disp_x < 512 and disp_y < 128, compared unsigned on all 11 bits (7ff is outside).
REQ-013 SHALL accept a write when wr_valid and wr_ready are both high on a clock edge; wr_ready = FIFO not full, independent of a same-cycle pop.
REQ-014 SHALL hold accepted requests in a FIFO_DEPTH-entry FIFO in arrival order; no request is dropped or reordered.
REQ-015 SHALL run a registered 3-state FSM: DISP, WRITE, IDLE; next state DISP if act, else WRITE if FIFO non-empty, else IDLE; display always has priority.
REQ-016 SHALL in DISP drive registered mem_addr = {disp_y[6:0], disp_x[8:0]}, mem_we = 0.
REQ-017 SHALL in WRITE pop one FIFO entry per cycle and drive registered mem_addr/mem_wdata from it with mem_we = 1.
REQ-018 SHALL in IDLE drive mem_we = 0 and hold mem_addr.
REQ-019 SHALL present rgb_out = mem_rdata exactly 2 cycles after act disp_x/disp_y are sampled; rgb_out = 0 for pixels that were not act.
REQ-020 SHALL, if act rises while FIFO is non-empty, stop popping in that same cycle; the pending entry stays at the FIFO head.
REQ-021 SHALL allow simultaneous push and pop when FIFO is neither full nor empty; occupancy unchanged.
REQ-022 SHALL increment frame_cnt on each frame_start pulse, wrapping 255 -> 0.
REQ-023 SHALL drive wr_pending high exactly when FIFO occupancy is nonzero.

Reset
REQ-024 SHALL on reset_n low asynchronously: FSM -> IDLE, FIFO flushed (in-flight requests discarded), wr_ready = 1 only after reset release, mem_we = 0, mem_addr = 0, mem_wdata = 0, rgb_out = 0, frame_cnt = 0, wr_pending = 0.
REQ-025 SHALL drive wr_ready = 0 while reset_n is low.
REQ-026 SHALL not issue mem_we on the first cycle after reset release.

Structure
REQ-027 SHALL place window constants (WIN_W = 512, WIN_H = 128, OFF_X = 11'h7ff) and the FSM state enum in shared package vga_pkg.
REQ-028 SHALL implement the write FIFO as one sub-module, vga_wr_fifo (parameters DW+AW, FIFO_DEPTH; push/pop/full/empty).

Verification
REQ-029 SHALL cover: disp_x = 5, disp_y = 3, mem_rdata model = address -> mem_addr = 0x0605, rgb_out = model data 2 cycles later.
REQ-030 SHALL cover: 5 writes pushed back-to-back in blanking-free window -> wr_ready low after 4 accepts, 5th accepted only after first drain.
REQ-031 SHALL cover: write (addr 0x1234, data 0xABC) during act, act drops -> exactly one mem_we cycle with those values, in the first non-act cycle.
REQ-032 SHALL cover: act rises with 2 entries queued -> mem_we = 0 from that cycle; both entries written after act drops, in order.
REQ-033 SHALL cover: reset_n pulsed low with 3 entries queued -> wr_pending = 0, no mem_we afterwards, frame_cnt = 0.
REQ-034 SHALL cover: 256 frame_start pulses -> frame_cnt returns to 0.
